vga_timing_monitor: RTL and testbench
=====================================

# vga_timing_monitor

Receive-side checker for the 640x480 VGA output of the game top level. Samples the same hsync/vsync/12-bit RGB pins the top level drives, locks onto the frame structure, and recovers the pixel coordinate of every sample. Reports sticky timing-error flags, a frame counter and a per-frame pixel checksum. Used on-chip and in simulation to prove the display path end to end.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch; H_TOTAL = 800
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- clk25  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- hsync, vsync  in  1 each  active-low sync pins
- vga_r, vga_g, vga_b  in  4 each  pixel pins
- locked  out  1  frame structure verified
- rx_x, rx_y  out  10 each  recovered coordinate of rx_rgb
- rx_rgb  out  12  {r,g,b} delayed to align with rx_x/rx_y
- rx_active  out  1  locked && rx_x < 640 && rx_y < 480
- frame_done  out  1  one-cycle pulse per verified frame
- frame_count  out  16  verified frames, wraps at 65535 -> 0
- frame_sum  out  16  checksum of last verified frame
- err_hline, err_hsync_width, err_vframe, err_vsync_width  out  1 each  sticky error flags

## Operation
- Stage 1 registers all pins; stage 2 holds previous sync samples. hsync fall = s1 low and s2 high; rise likewise.
- Line counter: cleared on hsync fall, +1 otherwise, saturates at 1023. At each hsync fall it must read 799, else line error.
- hsync width counter: counts s1-low cycles, saturates at 127; at hsync rise it must read 96.
- Frame counter (19 bit): cleared on vsync fall, +1 otherwise, saturates at 524287. At each vsync fall it must read 419999 (800*525 - 1).
- vsync width: hsync falls seen while vsync low; must be 2 at vsync rise.
- Position: h_pos forced to 656 on hsync fall, else +1 wrapping 799 -> 0. v_pos +1 on h_pos wrap (524 -> 0); forced to 490 on vsync fall (takes precedence over the wrap increment).
- FSM SEARCH -> ACQUIRE on first vsync fall (counters cleared). ACQUIRE: any check failure restarts ACQUIRE with counters cleared; a vsync fall with a passing frame count and no failures since entry -> LOCKED. LOCKED: any check failure sets its flag and -> SEARCH. Several failures on one cycle set all matching flags.
- Error flags are set only in LOCKED; cleared only by reset.
- Checksum accumulator (16 bit, mod 2^16) adds zero-extended rx_rgb on every cycle rx_active is high.
- On a vsync fall in LOCKED with a passing frame count: frame_sum <= accumulator (including that cycle's addend), frame_count +1, frame_done = 1. Accumulator clears on every vsync fall, in every state.

## Timing
- Pin-to-rx_* latency: 2 cycles. Pins sampled at edge N appear on rx_x/rx_y/rx_rgb/rx_active after edge N+2.
- Lock asserts 1 cycle after the second valid vsync fall. It drops 1 cycle after the failing check.
- frame_done, frame_sum and frame_count update on the same cycle. The first frame_done comes at the third vsync fall after reset.
- Reset values: locked 0, rx_x 0, rx_y 0, rx_rgb 0, rx_active 0, frame_done 0, frame_count 0, frame_sum 0, all error flags 0. FSM = SEARCH, all counters 0.
- Reset mid-frame: everything returns to reset values on the next edge, and the lock sequence restarts from SEARCH.

## Test plan
- Nominal black-screen generator, reset released at a line start -> locked rises after 2nd vsync fall; frame_done every 420000 cycles; frame_sum 0x0000; no error flags.
- All pixels 12'hFFF -> frame_sum = 0x5000 (307200*4095 mod 65536); frame_count 1, 2, 3 on successive frame_done pulses.
- hsync fall on pin at cycle T while locked -> rx_x = 656 at T+2. First visible pixel after wrap -> rx_x = 0, rx_y = 0, rx_active = 1.
- While locked, stretch one line to 801 cycles -> err_hline = 1 and locked = 0. Normal stream resumes -> relock after 2 vsync falls; err_hline stays 1.
- While locked, one hsync pulse of 95 cycles -> err_hsync_width = 1. One vsync pulse spanning 3 hsync falls -> err_vsync_width = 1 (separate run).
- Assert reset mid-frame while locked with flags set -> all outputs 0 the next cycle; relock after 2 further vsync falls.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Receive-side checker for the VGA pins: locks onto hsync/vsync timing, recovers
// the pixel coordinate of every sample, flags timing faults and checksums each frame.
module vga_timing_monitor #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        locked,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [11:0] rx_rgb,
    output logic        rx_active,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [15:0] frame_sum,
    output logic        err_hline,
    output logic        err_hsync_width,
    output logic        err_vframe,
    output logic        err_vsync_width
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_POS = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  V_SYNC_POS = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [6:0]  HS_WIDTH   = 7'(H_SYNC);
    localparam logic [3:0]  VS_WIDTH   = 4'(V_SYNC);
    localparam logic [18:0] FRAME_LAST = 19'(H_TOTAL * V_TOTAL - 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state_q;
    logic        locked_q;
    logic        hs_seen_q, vs_seen_q;
    logic        err_hline_q, err_hsw_q, err_vframe_q, err_vsw_q;
    logic        frame_done_q;
    logic [15:0] frame_count_q, frame_sum_q;

    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [11:0] rgb_s1_q, rgb_s2_q;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [6:0]  hsw_cnt_q, hsw_cnt_d;
    logic [18:0] frm_cnt_q, frm_cnt_d;
    logic [3:0]  vsw_cnt_q, vsw_cnt_d;
    logic [9:0]  h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    logic [15:0] acc_q, acc_d, acc_sum;
    logic [9:0]  rx_x_q, rx_y_q;
    logic [11:0] rx_rgb_q;

    logic hs_fall, hs_rise, vs_fall, vs_rise;
    logic e_hline, e_hsw, e_vframe, e_vsw, any_err, frame_ok;

    assign hs_fall = !hs_s1_q && hs_s2_q;
    assign hs_rise = hs_s1_q && !hs_s2_q;
    assign vs_fall = !vs_s1_q && vs_s2_q;
    assign vs_rise = vs_s1_q && !vs_s2_q;

    // A check is armed only once its own reference edge has been seen since (re)entry.
    assign e_hline  = hs_fall && hs_seen_q && (line_cnt_q != H_LAST);
    assign e_hsw    = hs_rise && hs_seen_q && (hsw_cnt_q != HS_WIDTH);
    assign e_vframe = vs_fall && vs_seen_q && (frm_cnt_q != FRAME_LAST);
    assign e_vsw    = vs_rise && vs_seen_q && (vsw_cnt_q != VS_WIDTH);
    assign any_err  = e_hline || e_hsw || e_vframe || e_vsw;
    assign frame_ok = vs_fall && vs_seen_q && (frm_cnt_q == FRAME_LAST);

    assign acc_sum = acc_q + (rx_active ? {4'd0, rx_rgb_q} : 16'd0);

    always_comb begin
        line_cnt_d = hs_fall ? 10'd0 : ((line_cnt_q == 10'h3FF) ? line_cnt_q : line_cnt_q + 10'd1);
        hsw_cnt_d  = hs_s1_q ? 7'd0 : ((hsw_cnt_q == 7'h7F) ? hsw_cnt_q : hsw_cnt_q + 7'd1);
        frm_cnt_d  = vs_fall ? 19'd0 : ((frm_cnt_q == 19'h7FFFF) ? frm_cnt_q : frm_cnt_q + 19'd1);
        vsw_cnt_d  = vsw_cnt_q;
        if (vs_fall)
            vsw_cnt_d = {3'd0, hs_fall};
        else if (!vs_s1_q && hs_fall && (vsw_cnt_q != 4'hF))
            vsw_cnt_d = vsw_cnt_q + 4'd1;

        h_pos_d = hs_fall ? H_SYNC_POS : ((h_pos_q == H_LAST) ? 10'd0 : h_pos_q + 10'd1);
        v_pos_d = v_pos_q;
        if (vs_fall)
            v_pos_d = V_SYNC_POS;
        else if (!hs_fall && (h_pos_q == H_LAST))
            v_pos_d = (v_pos_q == V_LAST) ? 10'd0 : v_pos_q + 10'd1;

        acc_d = vs_fall ? 16'd0 : acc_sum;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            hs_s1_q    <= 1'b1;
            hs_s2_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            vs_s2_q    <= 1'b1;
            rgb_s1_q   <= '0;
            rgb_s2_q   <= '0;
            line_cnt_q <= '0;
            hsw_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            vsw_cnt_q  <= '0;
            h_pos_q    <= '0;
            v_pos_q    <= '0;
            acc_q      <= '0;
            rx_x_q     <= '0;
            rx_y_q     <= '0;
            rx_rgb_q   <= '0;
        end else begin
            hs_s1_q    <= hsync;
            hs_s2_q    <= hs_s1_q;
            vs_s1_q    <= vsync;
            vs_s2_q    <= vs_s1_q;
            rgb_s1_q   <= {vga_r, vga_g, vga_b};
            rgb_s2_q   <= rgb_s1_q;
            line_cnt_q <= line_cnt_d;
            hsw_cnt_q  <= hsw_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            vsw_cnt_q  <= vsw_cnt_d;
            h_pos_q    <= h_pos_d;
            v_pos_q    <= v_pos_d;
            acc_q      <= acc_d;
            rx_x_q     <= h_pos_q;
            rx_y_q     <= v_pos_q;
            rx_rgb_q   <= rgb_s2_q;
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q       <= SEARCH;
            locked_q      <= 1'b0;
            hs_seen_q     <= 1'b0;
            vs_seen_q     <= 1'b0;
            err_hline_q   <= 1'b0;
            err_hsw_q     <= 1'b0;
            err_vframe_q  <= 1'b0;
            err_vsw_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            frame_sum_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            hs_seen_q    <= hs_seen_q | hs_fall;
            vs_seen_q    <= vs_seen_q | vs_fall;
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q   <= ACQUIRE;
                        hs_seen_q <= hs_fall;
                        vs_seen_q <= 1'b1;
                    end
                end
                ACQUIRE: begin
                    // Restart: only measurements begun on this very cycle stay valid.
                    if (any_err) begin
                        hs_seen_q <= hs_fall;
                        vs_seen_q <= vs_fall;
                    end else if (frame_ok) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_q      <= SEARCH;
                        locked_q     <= 1'b0;
                        err_hline_q  <= err_hline_q | e_hline;
                        err_hsw_q    <= err_hsw_q | e_hsw;
                        err_vframe_q <= err_vframe_q | e_vframe;
                        err_vsw_q    <= err_vsw_q | e_vsw;
                    end else if (frame_ok) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        frame_sum_q   <= acc_sum;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked          = locked_q;
    assign rx_x            = rx_x_q;
    assign rx_y            = rx_y_q;
    assign rx_rgb          = rx_rgb_q;
    assign rx_active       = locked_q && (rx_x_q < H_VIS) && (rx_y_q < V_VIS);
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign frame_sum       = frame_sum_q;
    assign err_hline       = err_hline_q;
    assign err_hsync_width = err_hsw_q;
    assign err_vframe      = err_vframe_q;
    assign err_vsync_width = err_vsw_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a reduced 25x15 raster (375 cycles per frame)
// driven by a pin generator with injectable line, hsync and vsync faults.
module tb_vga_timing_monitor;
    localparam int HV = 16, HFP = 2, HSW = 4, HBP = 3, HT = HV + HFP + HSW + HBP;
    localparam int VV = 8,  VFP = 2, VSW = 2, VBP = 3, VT = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int HS0 = HV + HFP, VS0 = VV + VFP;

    logic        clk25 = 1'b0, reset = 1'b1;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        locked, rx_active, frame_done;
    logic [9:0]  rx_x, rx_y;
    logic [11:0] rx_rgb;
    logic [15:0] frame_count, frame_sum;
    logic        err_hline, err_hsync_width, err_vframe, err_vsync_width;
    logic [3:0]  errs;

    assign errs = {err_hline, err_hsync_width, err_vframe, err_vsync_width};

    vga_timing_monitor #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk25(clk25), .reset(reset), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .locked(locked), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
        .rx_active(rx_active), .frame_done(frame_done),
        .frame_count(frame_count), .frame_sum(frame_sum),
        .err_hline(err_hline), .err_hsync_width(err_hsync_width),
        .err_vframe(err_vframe), .err_vsync_width(err_vsync_width)
    );

    initial forever #5 clk25 = ~clk25;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int x, input int y, input int mode);
        if (mode == 0) return 12'h000;
        if (mode == 1) return 12'hFFF;
        return 12'(x * 37 + y * 113 + 5);
    endfunction

    // Pin generator: drives on the falling edge, logs what it drove per negedge.
    int gh = 0, gv = 0, neg_cnt = 0, pix_mode = 0;
    int vfall_neg = 0, vrise_neg = 0, hfall_neg = 0, hrise_neg = 0, vfall_count = 0;
    bit stretch_req = 0, short_hs_req = 0, long_vs_req = 0;
    int hist_x [8];
    int hist_y [8];
    logic [11:0] hist_rgb [8];

    initial begin
        bit hs_n, vs_n, prev_hs, prev_vs, hs_cut, vs_ext;
        logic [11:0] rgb;
        prev_hs = 1; prev_vs = 1; hs_cut = 0; vs_ext = 0;
        forever begin
            @(negedge clk25);
            neg_cnt++;
            if (gh == 0 && gv == 0) begin vs_ext = long_vs_req; long_vs_req = 0; end
            if (gh == 0) begin hs_cut = short_hs_req; short_hs_req = 0; end
            hs_n = !(gh >= HS0 && gh < HS0 + HSW - int'(hs_cut));
            vs_n = !(gv >= VS0 && gv < VS0 + VSW + int'(vs_ext));
            rgb  = (gh < HV && gv < VV) ? pix(gh, gv, pix_mode) : 12'h000;
            hsync = hs_n; vsync = vs_n;
            vga_r = rgb[11:8]; vga_g = rgb[7:4]; vga_b = rgb[3:0];
            if (!vs_n && prev_vs) begin vfall_neg = neg_cnt; vfall_count++; end
            if (vs_n && !prev_vs) vrise_neg = neg_cnt;
            if (!hs_n && prev_hs) hfall_neg = neg_cnt;
            if (hs_n && !prev_hs) hrise_neg = neg_cnt;
            prev_hs = hs_n; prev_vs = vs_n;
            hist_x[neg_cnt & 7] = gh; hist_y[neg_cnt & 7] = gv; hist_rgb[neg_cnt & 7] = rgb;
            if (gh == HT - 1) begin
                if (stretch_req) stretch_req = 0;
                else begin gh = 0; gv = (gv == VT - 1) ? 0 : gv + 1; end
            end else gh++;
        end
    end

    // sel: 0 locked, 1 frame_done, 2 err_hline, 3 err_hsync_width, 4 err_vsync_width, 5 gv==3
    task automatic wait_sig(input string tag, input int sel, input int limit);
        bit hit;
        hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk25); #1;
            case (sel)
                0: hit = locked;
                1: hit = frame_done;
                2: hit = err_hline;
                3: hit = err_hsync_width;
                4: hit = err_vsync_width;
                default: hit = (gv == 3);
            endcase
        end
        chk({tag, "_reached"}, 32'(hit), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_rx_x"}, 32'(rx_x), 0);
        chk({tag, "_rx_y"}, 32'(rx_y), 0);
        chk({tag, "_rx_rgb"}, 32'(rx_rgb), 0);
        chk({tag, "_rx_active"}, 32'(rx_active), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_frame_count"}, 32'(frame_count), 0);
        chk({tag, "_frame_sum"}, 32'(frame_sum), 0);
        chk({tag, "_errs"}, 32'(errs), 0);
    endtask

    initial begin
        int v0, t1, bad, k, hf_x, fv_x, fv_y, fv_act, model_sum;

        // Reset state, then nominal black screen
        repeat (3) @(negedge clk25);
        #1;
        check_all_zero("rst");
        reset = 0;
        v0 = vfall_count;
        wait_sig("lock_a", 0, 4 * FRAME);
        chk("lock_vfalls", 32'(vfall_count - v0), 2);
        chk("lock_lat", 32'(neg_cnt - vfall_neg), 2);
        wait_sig("fd_a1", 1, 2 * FRAME);
        chk("fd1_vfalls", 32'(vfall_count - v0), 3);
        chk("fd1_lat", 32'(neg_cnt - vfall_neg), 2);
        chk("fd1_count", 32'(frame_count), 1);
        chk("fd1_sum_black", 32'(frame_sum), 16'h0000);
        t1 = neg_cnt;
        wait_sig("fd_a2", 1, 2 * FRAME);
        chk("fd_period", 32'(neg_cnt - t1), FRAME);
        chk("fd2_count", 32'(frame_count), 2);
        chk("a_errs", 32'(errs), 0);
        chk("a_locked", 32'(locked), 1);

        // All-white frames: 128 * 0xFFF mod 2^16 = 0xFF80
        pix_mode = 1;
        @(negedge clk25); #1;
        reset = 1;
        repeat (2) @(negedge clk25);
        #1;
        chk("b_rst_count", 32'(frame_count), 0);
        reset = 0;
        for (int f = 1; f <= 3; f++) begin
            wait_sig("fd_b", 1, 5 * FRAME);
            chk("b_count", 32'(frame_count), 32'(f));
            chk("b_sum_white", 32'(frame_sum), 16'hFF80);
        end

        // Coordinate pattern: checksum against model, then coordinate alignment
        pix_mode = 2;
        model_sum = 0;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                model_sum += int'(pix(x, y, 2));
        wait_sig("fd_c1", 1, 2 * FRAME);
        wait_sig("fd_c2", 1, 2 * FRAME);
        chk("c_sum_pattern", 32'(frame_sum), 32'(model_sum & 16'hFFFF));
        bad = 0; hf_x = -1; fv_x = -1; fv_y = -1; fv_act = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk25); #1;
            k = (neg_cnt - 3) & 7;
            if (rx_x !== 10'(hist_x[k]) || rx_y !== 10'(hist_y[k]) || rx_rgb !== hist_rgb[k] ||
                rx_active !== (hist_x[k] < HV && hist_y[k] < VV))
                bad++;
            if (neg_cnt - hfall_neg == 3) hf_x = int'(rx_x);
            if (hist_x[k] == 0 && hist_y[k] == 0) begin
                fv_x = int'(rx_x); fv_y = int'(rx_y); fv_act = int'(rx_active);
            end
        end
        chk("c_align_bad", 32'(bad), 0);
        chk("c_hfall_x", 32'(hf_x), HS0);
        chk("c_first_x", 32'(fv_x), 0);
        chk("c_first_y", 32'(fv_y), 0);
        chk("c_first_active", 32'(fv_act), 1);

        // Stretched line while locked
        stretch_req = 1;
        wait_sig("d_err", 2, 2 * FRAME);
        chk("d_lat", 32'(neg_cnt - hfall_neg), 2);
        chk("d_errs", 32'(errs), 4'b1000);
        chk("d_locked", 32'(locked), 0);
        v0 = vfall_count;
        wait_sig("d_relock", 0, 4 * FRAME);
        chk("d_relock_vfalls", 32'(vfall_count - v0), 2);
        chk("d_errs_sticky", 32'(errs), 4'b1000);

        // Short hsync pulse while locked
        short_hs_req = 1;
        wait_sig("e_err", 3, 2 * FRAME);
        chk("e_lat", 32'(neg_cnt - hrise_neg), 2);
        chk("e_errs", 32'(errs), 4'b1100);
        chk("e_locked", 32'(locked), 0);
        wait_sig("e_relock", 0, 4 * FRAME);

        // Mid-frame reset while locked with flags set
        wait_sig("g_mid", 5, 2 * FRAME);
        chk("g_pre_locked", 32'(locked), 1);
        reset = 1;
        @(negedge clk25); #1;
        check_all_zero("g_rst");
        reset = 0;
        v0 = vfall_count;
        wait_sig("g_relock", 0, 4 * FRAME);
        chk("g_relock_vfalls", 32'(vfall_count - v0), 2);

        // Vsync pulse spanning three hsync falls
        long_vs_req = 1;
        wait_sig("f_err", 4, 3 * FRAME);
        chk("f_lat", 32'(neg_cnt - vrise_neg), 2);
        chk("f_errs", 32'(errs), 4'b0001);
        chk("f_locked", 32'(locked), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
